// File: rtl/i2c_reg_bridge.sv
// Register-file back end for i2c_slave: the first write byte sets a pointer, later bytes
// stream through consecutive registers. A host port has direct access to the same file.
module i2c_reg_bridge #(
    parameter int AW = 4,
    parameter logic [(2**AW)-1:0] RO_MASK = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_active,
    input  logic          rx_strobe,
    input  logic [7:0]    rx_data,
    input  logic          tx_strobe,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          reg_changed,
    output logic [AW-1:0] changed_addr
);

    localparam int NREG = 2**AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PTR,
        S_DATA
    } state_t;

    state_t        state;
    logic [7:0]    regs [NREG];
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_next;
    logic          rx_q, tx_q, bus_q;
    logic          rx_rise, tx_rise, bus_rise, bus_fall;
    logic          i2c_we;
    logic          tx_stale;

    assign rx_rise  = rx_strobe & ~rx_q;
    assign tx_rise  = tx_strobe & ~tx_q;
    assign bus_rise = bus_active & ~bus_q;
    assign bus_fall = ~bus_active & bus_q;

    // rx wins over a simultaneous tx edge, so the pointer only ever moves once per cycle.
    always_comb begin
        ptr_next = ptr;
        i2c_we   = 1'b0;
        if (!bus_fall) begin
            if (state == S_PTR && rx_rise) begin
                ptr_next = rx_data[AW-1:0];
            end else if ((state == S_PTR || state == S_DATA) && (rx_rise || tx_rise)) begin
                ptr_next = ptr + AW'(1);
                i2c_we   = (state == S_DATA) && rx_rise && !RO_MASK[ptr];
            end
        end
    end

    // tx_data trails regs[ptr] by one cycle, so flag it whenever its source moves.
    assign tx_stale = (ptr_next != ptr) || i2c_we || (host_we && host_addr == ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            rx_q         <= 1'b0;
            tx_q         <= 1'b0;
            bus_q        <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            host_rdata   <= '0;
            reg_changed  <= 1'b0;
            changed_addr <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            rx_q        <= rx_strobe;
            tx_q        <= tx_strobe;
            bus_q       <= bus_active;
            ptr         <= ptr_next;
            tx_data     <= regs[ptr];
            tx_valid    <= ~tx_stale;
            host_rdata  <= regs[host_addr];
            reg_changed <= i2c_we;

            if (bus_fall) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  if (bus_rise) state <= S_PTR;
                    S_PTR:   if (rx_rise || tx_rise) state <= S_DATA;
                    S_DATA:  state <= S_DATA;
                    default: state <= S_IDLE;
                endcase
            end

            // Host write first so a same-address I2C write in this cycle overrides it.
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            if (i2c_we) begin
                regs[ptr]    <= rx_data;
                changed_addr <= ptr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed bench for i2c_reg_bridge; reg_changed pulses are checked against a queue of
// expected addresses pushed as each I2C data byte is driven.
module tb_i2c_reg_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       bus_active;
    logic       rx_strobe;
    logic [7:0] rx_data;
    logic       tx_strobe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       reg_changed;
    logic [3:0] changed_addr;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_a;

    always #5 clk = ~clk;

    i2c_reg_bridge #(.AW(4), .RO_MASK(16'h0004)) dut (
        .clk(clk), .rst(rst), .bus_active(bus_active),
        .rx_strobe(rx_strobe), .rx_data(rx_data), .tx_strobe(tx_strobe),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .reg_changed(reg_changed), .changed_addr(changed_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_reg_changed observed_addr=%0h expected=no_pulse", changed_addr);
            end else begin
                exp_a = exp_q.pop_front();
                assert (changed_addr === exp_a) else begin
                    errors++;
                    $error("FAIL changed_addr observed=%0h expected=%0h", changed_addr, exp_a);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        bus_active = 1'b1;
        tick(2);
    endtask

    task automatic bus_stop();
        bus_active = 1'b0;
        tick(2);
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit chk_stale);
        rx_data   = b;
        rx_strobe = 1'b1;
        tick(1);
        if (chk_stale) check("tx_valid_stale", tx_valid, 1'b0);
        tick(2);
        rx_strobe = 1'b0;
        tick(3);
    endtask

    task automatic tx_byte();
        tx_strobe = 1'b1;
        tick(3);
        tx_strobe = 1'b0;
        tick(3);
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        host_addr = a;
        tick(2);
        check(tag, host_rdata, exp);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        tick(1);
        host_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_active = 1'b0; rx_strobe = 1'b0; rx_data = '0;
        tx_strobe = 1'b0; host_addr = '0; host_we = 1'b0; host_wdata = '0;
        tick(3);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_reg_changed", reg_changed, 1'b0);
        rst = 1'b0;
        tick(2);
        check("idle_tx_valid", tx_valid, 1'b1);

        // reset mid-write
        bus_start();
        rx_byte(8'h01, 1'b1);
        exp_q.push_back(4'h1);
        rx_byte(8'h12, 1'b1);
        rst = 1'b1; bus_active = 1'b0;
        tick(1);
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_changed_addr", changed_addr, 4'h0);
        check("midrst_ptr", dut.ptr, 4'h0);
        rst = 1'b0;
        tick(2);
        host_read(4'h1, 8'h00, "midrst_reg1_cleared");
        bus_start();
        rx_byte(8'h07, 1'b1);
        check("post_rst_ptr_byte", dut.ptr, 4'h7);
        bus_stop();

        // write sequence
        bus_start();
        rx_byte(8'h03, 1'b1);
        exp_q.push_back(4'h3);
        rx_byte(8'hAA, 1'b1);
        exp_q.push_back(4'h4);
        rx_byte(8'h55, 1'b1);
        check("wr_ptr", dut.ptr, 4'h5);
        check("wr_tx_valid_settled", tx_valid, 1'b1);
        bus_stop();
        host_read(4'h3, 8'hAA, "wr_reg3");
        host_read(4'h4, 8'h55, "wr_reg4");

        // read sequence
        bus_start();
        rx_byte(8'h03, 1'b0);
        bus_stop();
        bus_start();
        check("rd_tx_data0", tx_data, 8'hAA);
        tx_byte();
        check("rd_tx_data1", tx_data, 8'h55);
        tx_byte();
        check("rd_ptr", dut.ptr, 4'h5);
        bus_stop();

        // pointer wrap
        bus_start();
        rx_byte(8'h0F, 1'b1);
        exp_q.push_back(4'hF);
        rx_byte(8'h11, 1'b1);
        exp_q.push_back(4'h0);
        rx_byte(8'h22, 1'b1);
        check("wrap_ptr", dut.ptr, 4'h1);
        bus_stop();
        host_read(4'hF, 8'h11, "wrap_reg15");
        host_read(4'h0, 8'h22, "wrap_reg0");

        // read-only register, upper pointer bits ignored
        bus_start();
        rx_byte(8'hF2, 1'b1);
        check("ro_ptr_set", dut.ptr, 4'h2);
        rx_byte(8'h77, 1'b1);
        check("ro_ptr", dut.ptr, 4'h3);
        bus_stop();
        host_read(4'h2, 8'h00, "ro_reg2_unchanged");
        host_write(4'h2, 8'h77);
        host_read(4'h2, 8'h77, "ro_host_write");

        // collisions: same address then different addresses
        bus_start();
        rx_byte(8'h04, 1'b1);
        host_addr = 4'h4; host_wdata = 8'h01; host_we = 1'b1;
        rx_data = 8'h99; rx_strobe = 1'b1;
        exp_q.push_back(4'h4);
        tick(1);
        host_we = 1'b0;
        tick(1);
        check("coll_host_rdata", host_rdata, 8'h99);
        tick(1);
        rx_strobe = 1'b0;
        tick(3);
        host_addr = 4'h6; host_wdata = 8'h66; host_we = 1'b1;
        rx_data = 8'hA5; rx_strobe = 1'b1;
        exp_q.push_back(4'h5);
        tick(1);
        host_we = 1'b0;
        tick(2);
        rx_strobe = 1'b0;
        tick(3);
        check("coll_ptr", dut.ptr, 4'h6);
        bus_stop();
        host_read(4'h5, 8'hA5, "coll_reg5_i2c");
        host_read(4'h6, 8'h66, "coll_reg6_host");

        // strobes while idle are ignored
        rx_byte(8'hEE, 1'b0);
        tx_byte();
        check("idle_ptr", dut.ptr, 4'h6);
        host_read(4'h6, 8'h66, "idle_reg6");

        tick(4);
        check("pulses_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
